// File: rtl/ftq_pkg.sv
// Shared FTQ sizing, pointer and entry types.
package ftq_pkg;

  localparam int DEPTH  = 16;
  localparam int PTR_W  = 4;
  localparam int PC_W   = 32;
  localparam int META_W = 24;

  // Extra MSB is the wrap bit: full/empty are told apart by it.
  typedef logic [PTR_W:0]   ptr_t;
  typedef logic [PTR_W-1:0] idx_t;

  typedef struct packed {
    logic [PC_W-1:0]   start_pc;
    logic [PC_W-1:0]   target_pc;
    logic              taken;
    logic [META_W-1:0] meta;
  } ftq_entry_t;

  function automatic idx_t ptrIdx(input ptr_t p);
    return p[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_target_queue_if.sv
// FTQ bus: BPU enqueue, ICache fetch issue, commit, control and index lookup.
interface fetch_target_queue_if;
  import ftq_pkg::*;

  logic              FTQStop;
  logic              FTQFlash;
  logic              FTQReq;
  logic              BpuValid;
  logic [PC_W-1:0]   BpuStartPc;
  logic [PC_W-1:0]   BpuTargetPc;
  logic              BpuTaken;
  logic [META_W-1:0] BpuMeta;
  logic              BpuReady;
  logic              FetchValid;
  logic [PC_W-1:0]   FetchPc;
  logic [PTR_W-1:0]  FetchIdx;
  logic              FetchReady;
  logic              CommitValid;
  logic [PTR_W-1:0]  RdIdx;
  logic [PC_W-1:0]   RdStartPc;
  logic [PC_W-1:0]   RdTargetPc;
  logic              RdTaken;
  logic [META_W-1:0] RdMeta;
  logic [PTR_W:0]    Count;

  modport slave (
    input  FTQStop, FTQFlash, BpuValid, BpuStartPc, BpuTargetPc, BpuTaken, BpuMeta,
           FetchReady, CommitValid, RdIdx,
    output FTQReq, BpuReady, FetchValid, FetchPc, FetchIdx,
           RdStartPc, RdTargetPc, RdTaken, RdMeta, Count
  );

  modport master (
    output FTQStop, FTQFlash, BpuValid, BpuStartPc, BpuTargetPc, BpuTaken, BpuMeta,
           FetchReady, CommitValid, RdIdx,
    input  FTQReq, BpuReady, FetchValid, FetchPc, FetchIdx,
           RdStartPc, RdTargetPc, RdTaken, RdMeta, Count
  );

endinterface

// File: rtl/ftq_ram.sv
// FTQ entry storage: one synchronous write, async fetch-PC and lookup reads.
// Storage is deliberately unreset; reads of unwritten entries are don't-care.
module ftq_ram
  import ftq_pkg::*;
(
  input  logic            Clk,
  input  logic            wrEn,
  input  idx_t            wrIdx,
  input  ftq_entry_t      wrData,
  input  idx_t            fetchIdx,
  output logic [PC_W-1:0] fetchPc,
  input  idx_t            rdIdx,
  output ftq_entry_t      rdData
);

  ftq_entry_t mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (wrEn) mem[wrIdx] <= wrData;
  end

  assign fetchPc = mem[fetchIdx].start_pc;
  assign rdData  = mem[rdIdx];

endmodule

// File: rtl/fetch_target_queue.sv
// Fetch target queue: BPU blocks in, in-order fetch issue, held until commit.
// Latency enqueue->FetchValid 1 cycle (0 with FTQ_BYPASS_EN); full deasserts BpuReady.
// Backpressure: FTQStop freezes enqueue/issue, FTQFlash clears all pointers.
module fetch_target_queue
  import ftq_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Rest,
  fetch_target_queue_if.slave  io
);

  ptr_t enqPtr, fetchPtr, commitPtr;

  logic            full;
  logic            unissued;
  logic            enqFire;
  logic            fetchFire;
  logic            commitFire;
  logic            bypass;
  logic [PC_W-1:0] ramFetchPc;
  ftq_entry_t      wrEntry;
  ftq_entry_t      rdEntry;

  assign full     = (enqPtr[PTR_W] != commitPtr[PTR_W]) &&
                    (ptrIdx(enqPtr) == ptrIdx(commitPtr));
  assign unissued = (fetchPtr != enqPtr);

  // Rest gates BpuReady so nothing is accepted while reset is held.
  assign io.BpuReady = Rest & ~full & ~io.FTQStop & ~io.FTQFlash;
  assign enqFire     = io.BpuValid & io.BpuReady;

`ifdef FTQ_BYPASS_EN
  assign bypass = enqFire & ~unissued;
`else
  assign bypass = 1'b0;
`endif

  assign io.FetchValid = (unissued & ~io.FTQStop & ~io.FTQFlash) | bypass;
  assign io.FetchPc    = bypass ? io.BpuStartPc : ramFetchPc;
  // When bypassing, fetchPtr == enqPtr so the index is the one being written.
  assign io.FetchIdx   = ptrIdx(fetchPtr);
  assign fetchFire     = io.FetchValid & io.FetchReady;

  assign commitFire = io.CommitValid & (commitPtr != fetchPtr) & ~io.FTQFlash;

  assign io.FTQReq = full;
  assign io.Count  = enqPtr - commitPtr;

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      enqPtr    <= '0;
      fetchPtr  <= '0;
      commitPtr <= '0;
    end else if (io.FTQFlash) begin
      enqPtr    <= '0;
      fetchPtr  <= '0;
      commitPtr <= '0;
    end else begin
      if (enqFire)    enqPtr    <= enqPtr + ptr_t'(1);
      if (fetchFire)  fetchPtr  <= fetchPtr + ptr_t'(1);
      if (commitFire) commitPtr <= commitPtr + ptr_t'(1);
    end
  end

  assign wrEntry = '{start_pc:  io.BpuStartPc,
                     target_pc: io.BpuTargetPc,
                     taken:     io.BpuTaken,
                     meta:      io.BpuMeta};

  ftq_ram uRam (
    .Clk      (Clk),
    .wrEn     (enqFire),
    .wrIdx    (ptrIdx(enqPtr)),
    .wrData   (wrEntry),
    .fetchIdx (ptrIdx(fetchPtr)),
    .fetchPc  (ramFetchPc),
    .rdIdx    (io.RdIdx),
    .rdData   (rdEntry)
  );

  assign io.RdStartPc  = rdEntry.start_pc;
  assign io.RdTargetPc = rdEntry.target_pc;
  assign io.RdTaken    = rdEntry.taken;
  assign io.RdMeta     = rdEntry.meta;

endmodule

// File: tb/tb_fetch_target_queue.sv
// Directed bench for fetch_target_queue; bypass expectations follow FTQ_BYPASS_EN.
module tb_fetch_target_queue;

  logic Clk;
  logic Rest;
  int   compared;
  int   mismatched;

  fetch_target_queue_if bus();

  fetch_target_queue dut (
    .Clk  (Clk),
    .Rest (Rest),
    .io   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after it, checks follow 1 later.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idleInputs();
    bus.FTQStop     = 1'b0;
    bus.FTQFlash    = 1'b0;
    bus.BpuValid    = 1'b0;
    bus.BpuStartPc  = '0;
    bus.BpuTargetPc = '0;
    bus.BpuTaken    = 1'b0;
    bus.BpuMeta     = '0;
    bus.FetchReady  = 1'b0;
    bus.CommitValid = 1'b0;
    bus.RdIdx       = '0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    idleInputs();
    Rest = 1'b0;
    #12;
    check("rst_fetchvalid", bus.FetchValid, 0);
    check("rst_ftqreq", bus.FTQReq, 0);
    check("rst_count", bus.Count, 0);
    bus.BpuValid = 1'b1;
    settle();
    check("rst_bpuready", bus.BpuReady, 0);
    bus.BpuValid = 1'b0;
    step();
    Rest = 1'b1;
    step();

    // 1: single enqueue
    bus.BpuValid    = 1'b1;
    bus.BpuStartPc  = 32'h1C00_0000;
    bus.BpuTargetPc = 32'h1C00_0010;
    bus.BpuTaken    = 1'b1;
    bus.BpuMeta     = 24'hABCDEF;
    settle();
    check("t1_bpuready", bus.BpuReady, 1);
`ifdef FTQ_BYPASS_EN
    check("t1_bypass_valid", bus.FetchValid, 1);
`else
    check("t1_nobypass_valid", bus.FetchValid, 0);
`endif
    step();
    bus.BpuValid = 1'b0;
    settle();
    check("t1_fetchvalid", bus.FetchValid, 1);
    check("t1_fetchpc", bus.FetchPc, 32'h1C00_0000);
    check("t1_fetchidx", bus.FetchIdx, 0);
    check("t1_count", bus.Count, 1);
    check("t1_rdtarget", bus.RdTargetPc, 32'h1C00_0010);
    check("t1_rdtaken", bus.RdTaken, 1);
    check("t1_rdmeta", bus.RdMeta, 24'hABCDEF);

    // 2: fill to 16 with no fetch issue
    for (int i = 1; i < 16; i++) begin
      bus.BpuValid    = 1'b1;
      bus.BpuStartPc  = 32'h1000 + 32'(i) * 32'h10;
      bus.BpuTargetPc = 32'h9000 + 32'(i);
      bus.BpuTaken    = 1'b0;
      step();
    end
    settle();
    check("t2_count", bus.Count, 16);
    check("t2_ftqreq", bus.FTQReq, 1);
    check("t2_bpuready", bus.BpuReady, 0);
    bus.BpuValid    = 1'b0;
    bus.CommitValid = 1'b1;
    step();
    bus.CommitValid = 1'b0;
    settle();
    check("t2_commit_ignored", bus.Count, 16);
    check("t2_fetchidx_hold", bus.FetchIdx, 0);
    bus.RdIdx = 4'd5;
    settle();
    check("t2_rdstart5", bus.RdStartPc, 32'h1050);

    // 3: issue all, then commit while full and BpuValid high
    bus.FetchReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      settle();
      check("t3_issue_idx", bus.FetchIdx, i);
      check("t3_issue_pc", bus.FetchPc, (i == 0) ? 32'h1C00_0000 : 32'h1000 + 32'(i) * 32'h10);
      step();
    end
    bus.FetchReady = 1'b0;
    settle();
    check("t3_all_issued", bus.FetchValid, 0);
    check("t3_count_full", bus.Count, 16);
    bus.CommitValid = 1'b1;
    bus.BpuValid    = 1'b1;
    bus.BpuStartPc  = 32'h2000;
    settle();
    check("t3_full_bpuready", bus.BpuReady, 0);
    step();
    bus.CommitValid = 1'b0;
    settle();
    check("t3_count_after_commit", bus.Count, 15);
    check("t3_slot_visible", bus.BpuReady, 1);
    step();
    bus.BpuValid = 1'b0;
    bus.RdIdx    = 4'd0;
    settle();
    check("t3_count_refill", bus.Count, 16);
    check("t3_ftqreq", bus.FTQReq, 1);
    check("t3_wrap_valid", bus.FetchValid, 1);
    check("t3_wrap_idx", bus.FetchIdx, 0);
    check("t3_wrap_pc", bus.FetchPc, 32'h2000);
    check("t3_wrap_rd", bus.RdStartPc, 32'h2000);

    // 5: flash beats enqueue, fetch and commit
    bus.FTQFlash    = 1'b1;
    bus.BpuValid    = 1'b1;
    bus.FetchReady  = 1'b1;
    bus.CommitValid = 1'b1;
    settle();
    check("t5_flash_bpuready", bus.BpuReady, 0);
    check("t5_flash_fetchvalid", bus.FetchValid, 0);
    step();
    idleInputs();
    settle();
    check("t5_count", bus.Count, 0);
    check("t5_fetchvalid", bus.FetchValid, 0);
    check("t5_ftqreq", bus.FTQReq, 0);
    check("t5_fetchidx", bus.FetchIdx, 0);

    // 4: stop with 3 queued, one issued
    for (int i = 0; i < 3; i++) begin
      bus.BpuValid   = 1'b1;
      bus.BpuStartPc = 32'h3000 + 32'(i) * 32'h10;
      step();
    end
    bus.BpuValid   = 1'b0;
    bus.FetchReady = 1'b1;
    step();
    bus.FTQStop     = 1'b1;
    bus.CommitValid = 1'b1;
    settle();
    check("t4_stop_fetchvalid", bus.FetchValid, 0);
    check("t4_stop_bpuready", bus.BpuReady, 0);
    check("t4_count_before", bus.Count, 3);
    step();
    bus.CommitValid = 1'b0;
    settle();
    check("t4_commit_under_stop", bus.Count, 2);
    step();
    check("t4_fetchidx_hold", bus.FetchIdx, 1);
    bus.FTQStop    = 1'b0;
    bus.FetchReady = 1'b0;
    settle();
    check("t4_resume_valid", bus.FetchValid, 1);
    check("t4_resume_pc", bus.FetchPc, 32'h3010);
    check("t4_resume_count", bus.Count, 2);

    // 6: empty queue, enqueue with FetchReady high
    bus.FTQFlash = 1'b1;
    step();
    bus.FTQFlash   = 1'b0;
    bus.BpuValid   = 1'b1;
    bus.BpuStartPc = 32'h4000;
    bus.FetchReady = 1'b1;
    settle();
`ifdef FTQ_BYPASS_EN
    check("t6_bypass_valid", bus.FetchValid, 1);
    check("t6_bypass_pc", bus.FetchPc, 32'h4000);
    check("t6_bypass_idx", bus.FetchIdx, 0);
    step();
    bus.BpuValid = 1'b0;
    settle();
    check("t6_bypass_issued", bus.FetchValid, 0);
    check("t6_bypass_count", bus.Count, 1);
    bus.CommitValid = 1'b1;
    step();
    bus.CommitValid = 1'b0;
    settle();
    check("t6_bypass_commit", bus.Count, 0);
`else
    check("t6_no_bypass", bus.FetchValid, 0);
    step();
    bus.BpuValid = 1'b0;
    settle();
    check("t6_late_valid", bus.FetchValid, 1);
    check("t6_late_pc", bus.FetchPc, 32'h4000);
    check("t6_late_idx", bus.FetchIdx, 0);
    step();
    check("t6_issued", bus.FetchValid, 0);
    check("t6_count", bus.Count, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
